cond_sub_3072_512: RTL and testbench
====================================

// Module: cond_sub_3072_512
// PURPOSE
//  Downstream stage of the 3072-bit block-carry adder: final conditional subtraction for modular add.
//  Takes the adder's sum (x, qualified by its one-cycle en_out pulse) and modulus m.
//  Returns x-m when x>=m, else x.
//  Limb-serial: one 512-bit borrow-chained subtract per cycle keeps the datapath at one 513-bit subtractor.
// PARAMETERS
//  Size_add  3072  operand/result width in bits
//  block     512   limb width processed per cycle
//  Size_c0   6     number of limbs (Size_add/block)
// PORTS
//  clk      in   1         single clock, all state on posedge
//  rst_n    in   1         asynchronous, active-low reset
//  en       in   1         start pulse; x and m sampled when en=1 in IDLE
//  x        in   Size_add  value to reduce (adder sum c)
//  m        in   Size_add  modulus
//  c        out  Size_add  result register
//  en_out   out  1         one-cycle pulse: c valid
//  busy     out  1         high when state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, limb counter=0, borrow=0, x/m/diff regs=0, c=0, en_out=0, busy=0.
//  FSM: IDLE -> SUB -> DONE -> IDLE.
//  IDLE:
//   - en=1 at edge E0: latch x->xr, m->mr; cnt=0; borrow=0; go SUB.
//   - en=0: stay; en_out=0.
//  SUB, one limb per edge, edges E1..E6:
//   - {bo,d} = {1'b0,xr[cnt*block+:block]} - {1'b0,mr[cnt*block+:block]} - borrow (513-bit).
//   - diff[cnt*block+:block] <= d[block-1:0]; borrow <= d[block]; cnt <= cnt+1.
//   - At cnt==Size_c0-1: go DONE.
//  DONE, edge E7:
//   - borrow=1 (x<m): c <= xr. borrow=0 (x>=m): c <= diff.
//   - en_out <= 1; go IDLE.
//  Timing:
//   - en_out high exactly one cycle after E7 (latency 7 edges from en).
//   - c holds until the next DONE or reset.
//  busy: 1 from cycle after E0 through cycle before en_out rises.
//   - Back-to-back en accepted on the edge en_out asserts (state IDLE).
//  en while busy: ignored, no queueing; x/m inputs need only be stable at E0.
//  Boundary cases:
//   - x==m -> c=0.
//   - m=0 -> c=x.
//   - Borrow propagates across all 6 limbs, e.g. x=2^3071, m=1.
//  Widths: no carry-in from upstream; x treated as unsigned Size_add-bit, x<2m not checked.
//  Reset mid-operation: immediate abort, all regs to reset values; no en_out pulse produced.
// TESTING
//  1. x=5, m=3, en pulse -> 7 edges later en_out=1 for one cycle, c=2, busy low after.
//  2. x=3, m=5 -> c=3 (borrow path); x=m=0xABC...(random 3072b) -> c=0.
//  3. x=2^512, m=1 -> c=2^512-1 (limb0 all ones, limb1..5 zero): inter-limb borrow.
//  4. x=2^3072-1, m=2^3072-2 -> c=1; then x=2^3071, m=1 -> c=2^3071-1 (6-limb borrow).
//  5. en held high for 10 cycles with changing x -> only first x processed until en_out;
//     next accepted on en_out cycle.
//  6. rst_n low during SUB cnt=3 -> c=0, en_out=0, busy=0 immediately; no pulse afterward.

Source files
------------

// File: rtl/cond_sub_3072_512.sv
// Final conditional subtraction for modular add: c = (x >= m) ? x - m : x.
// Limb-serial: one borrow-chained block-wide subtract per cycle over Size_c0 limbs.
module cond_sub_3072_512 #(
  parameter int unsigned Size_add = 3072,
  parameter int unsigned block    = 512,
  parameter int unsigned Size_c0  = Size_add / block
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [Size_add-1:0] x,
  input  logic [Size_add-1:0] m,
  output logic [Size_add-1:0] c,
  output logic                en_out,
  output logic                busy
);

  localparam int unsigned CntW = (Size_c0 > 1) ? $clog2(Size_c0) : 1;
  localparam logic [CntW-1:0] LastLimb = CntW'(Size_c0 - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                borrow_q, borrow_d;
  logic [Size_add-1:0] xr_q, xr_d;
  logic [Size_add-1:0] mr_q, mr_d;
  logic [Size_add-1:0] diff_q, diff_d;
  logic [Size_add-1:0] c_q, c_d;
  logic                en_out_q, en_out_d;

  // Operands rotate one limb per SUB cycle so the active limb always sits at bit 0;
  // after Size_c0 rotations xr is back in its original order for the x < m case.
  logic [block:0] limb_sub;

  assign limb_sub = {1'b0, xr_q[block-1:0]} - {1'b0, mr_q[block-1:0]}
                  - {{block{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    xr_d     = xr_q;
    mr_d     = mr_q;
    diff_d   = diff_q;
    c_d      = c_q;
    en_out_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          xr_d     = x;
          mr_d     = m;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = StSub;
        end
      end

      StSub: begin
        // Each new limb enters at the top; after the last limb, limb 0 lands at bit 0.
        diff_d   = {limb_sub[block-1:0], diff_q[Size_add-1:block]};
        xr_d     = {xr_q[block-1:0], xr_q[Size_add-1:block]};
        mr_d     = {mr_q[block-1:0], mr_q[Size_add-1:block]};
        borrow_d = limb_sub[block];
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastLimb) begin
          state_d = StDone;
        end
      end

      StDone: begin
        c_d      = borrow_q ? xr_q : diff_q;
        en_out_d = 1'b1;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      xr_q     <= '0;
      mr_q     <= '0;
      diff_q   <= '0;
      c_q      <= '0;
      en_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      xr_q     <= xr_d;
      mr_q     <= mr_d;
      diff_q   <= diff_d;
      c_q      <= c_d;
      en_out_q <= en_out_d;
    end
  end

  assign c      = c_q;
  assign en_out = en_out_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_cond_sub_3072_512.sv
// Bench for cond_sub_3072_512: expected results queued at acceptance, compared on en_out.
module tb_cond_sub_3072_512;

  localparam int unsigned W = 3072;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] m = '0;
  logic [W-1:0] c;
  logic         en_out;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] sb[$];
  int           mdl_wait = 0;
  logic [W-1:0] mon_exp;
  logic         en_seen = 1'b0;

  cond_sub_3072_512 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .x      (x),
    .m      (m),
    .c      (c),
    .en_out (en_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int w;
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      w = 0;
      for (int i = W / 64 - 1; i >= 0; i--) begin
        if (obs[i*64+:64] !== exp[i*64+:64]) w = i;
      end
      $display("FAIL %s: got word%0d=%h, want %h", tag, w, obs[w*64+:64], exp[w*64+:64]);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] xv, input logic [W-1:0] mv);
    return (xv >= mv) ? xv - mv : xv;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32+:32] = $urandom;
    return v;
  endfunction

  // Protocol model: a request is taken in IDLE; the block is unavailable for 7 more edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      mdl_wait = 0;
    end else if (mdl_wait > 0) begin
      mdl_wait--;
    end else if (en) begin
      sb.push_back(ref_result(x, m));
      mdl_wait = 7;
    end
  end

  always @(negedge clk) begin
    if (rst_n && en_out) begin
      en_seen = 1'b1;
      if (sb.size() == 0) begin
        check("en_out_unexpected", W'(1), W'(0));
      end else begin
        mon_exp = sb.pop_front();
        check("c_result", c, mon_exp);
      end
    end
  end

  // Drive one request; returns 1 time unit after the accepting edge.
  task automatic start(input logic [W-1:0] xv, input logic [W-1:0] mv);
    @(posedge clk);
    #1;
    en = 1'b1;
    x  = xv;
    m  = mv;
    @(posedge clk);
    #1;
    en = 1'b0;
    x  = ~xv;
    m  = ~mv;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check(tag, W'(sb.size()), W'(0));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] mv);
    start(xv, mv);
    wait_drain(tag);
  endtask

  logic [W-1:0] one_w;
  logic [W-1:0] rx;
  logic [W-1:0] rm;

  initial begin
    one_w = W'(1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_c", c, W'(0));
    check("rst_en_out", W'(en_out), W'(0));
    check("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency and busy window for x=5, m=3
    start(W'(5), W'(3));
    @(negedge clk);
    check("busy_after_e0", W'(busy), W'(1));
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("en_out_early", W'(en_out), W'(0));
      check("busy_mid", W'(busy), W'(1));
    end
    @(posedge clk);
    @(negedge clk);
    check("en_out_e7", W'(en_out), W'(1));
    check("busy_at_done", W'(busy), W'(0));
    @(posedge clk);
    @(negedge clk);
    check("en_out_one_cycle", W'(en_out), W'(0));
    check("c_hold", c, W'(2));
    check("t1_drain", W'(sb.size()), W'(0));

    // Borrow path, equality, zero modulus
    run_op("t2_borrow", W'(3), W'(5));
    rx = rand_wide();
    run_op("t2_equal", rx, rx);
    run_op("t2_m_zero", rx, W'(0));

    // Inter-limb and full-width borrow chains
    run_op("t3_limb_borrow", one_w << 512, W'(1));
    rx = '1;
    run_op("t4_top", rx, rx - one_w);
    run_op("t4_six_limb", one_w << 3071, W'(1));

    // Random operands, both orderings
    for (int i = 0; i < 6; i++) begin
      rx = rand_wide();
      rm = rand_wide();
      if (i % 2 == 1) rm[W-1] = 1'b0;
      run_op("t_rand", rx, rm);
    end

    // en held high with changing x: only E0 and the en_out-cycle edge are taken
    @(posedge clk);
    #1;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = rand_wide();
      m = rand_wide() >> 1;
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    wait_drain("t5_held_en");

    // Abort mid-operation: c must be non-zero beforehand so the clear is visible
    run_op("t6_prep", W'(5), W'(3));
    start(W'(100), W'(1));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    en_seen = 1'b0;
    check("t6_rst_c", c, W'(0));
    check("t6_rst_en_out", W'(en_out), W'(0));
    check("t6_rst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_no_pulse", W'(en_seen), W'(0));
    check("t6_c_after", c, W'(0));

    run_op("t6_recover", W'(9), W'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
